btb_update_ctrl: RTL and testbench

Resolution-side writer for the 64-entry direct-mapped BTB. In EX it compares the IF-stage prediction carried down the pipe with the actual branch outcome and raises a registered flush/redirect on a mispredict. It queues the resulting BTB write transactions in a small FIFO and drains them onto the BTB update port (update_en / pc_update / actual_target / actual_taken), one per cycle, unless held.

---
 rtl/btb_pkg.sv | 21 ++
 rtl/btb_upd_fifo.sv | 57 +++++
 rtl/btb_update_ctrl.sv | 105 ++++++++++
 tb/tb_btb_update_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the BTB resolution-side update path.
package btb_pkg;
    localparam int BTB_INDEX_BITS = 6;
    localparam int BTB_XLEN       = 32;

    // One pending BTB write, ordered to match the BTB update port
    typedef struct packed {
        logic [BTB_XLEN-1:0] pc;
        logic [BTB_XLEN-1:0] target;
        logic                taken;
    } btb_upd_t;

    // Fall-through wraps modulo 2^XLEN
    function automatic logic [BTB_XLEN-1:0] calc_redirect(
        input logic                taken,
        input logic [BTB_XLEN-1:0] pc,
        input logic [BTB_XLEN-1:0] target
    );
        return taken ? target : pc + BTB_XLEN'(4);
    endfunction
endpackage

// File: rtl/btb_upd_fifo.sv
// DEPTH-entry FIFO of BTB writes; head visible combinationally, zero when empty.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  logic     pop_i,
    input  btb_upd_t din_i,
    output btb_upd_t dout_o,
    output logic     full_o,
    output logic     empty_o,
    output logic     drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    btb_upd_t      mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop_ok && !push_ok)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok)
                rd_q <= rd_q + AW'(1);
        end
    end
endmodule

// File: rtl/btb_update_ctrl.sv
// EX-stage BTB writer: registered flush/redirect on mispredict, FIFO-buffered BTB updates.
// Optional counters enabled by BTB_UPDATE_STATS_EN; hold stalls draining, full FIFO drops new writes.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_hit,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            ex_actual_taken,
    input  logic [XLEN-1:0] ex_actual_target,
    input  logic            hold,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            upd_en,
    output logic [XLEN-1:0] upd_pc,
    output logic [XLEN-1:0] upd_target,
    output logic            upd_taken,
    output logic            fifo_full
`ifdef BTB_UPDATE_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
    output logic [31:0]     stat_drops
`endif
);
    logic            res, mispred, enq;
    logic            flush_q, flush_d, shadow_q;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic            fifo_empty, fifo_drop;
    btb_upd_t        enq_entry, head;

    // The instruction in EX while flush is high is already wrong-path
    assign res     = ex_valid & ex_is_branch & ~shadow_q;
    assign mispred = (ex_pred_hit != ex_actual_taken) |
                     (ex_pred_hit & ex_actual_taken & (ex_pred_target != ex_actual_target));
    assign enq     = res & (ex_actual_taken | ex_pred_hit);

    assign flush_d    = res & mispred;
    assign redirect_d = flush_d ? calc_redirect(ex_actual_taken, ex_pc, ex_actual_target) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q    <= 1'b0;
            shadow_q   <= 1'b0;
            redirect_q <= '0;
        end else begin
            flush_q    <= flush_d;
            shadow_q   <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;

    assign enq_entry = '{pc: ex_pc, target: ex_actual_target, taken: ex_actual_taken};

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (enq),
        .pop_i   (upd_en),
        .din_i   (enq_entry),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign upd_en     = ~fifo_empty & ~hold;
    assign upd_pc     = head.pc;
    assign upd_target = head.target;
    assign upd_taken  = head.taken;

`ifdef BTB_UPDATE_STATS_EN
    logic [31:0] br_q, mp_q, dr_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q <= '0;
            mp_q <= '0;
            dr_q <= '0;
        end else begin
            if (res && br_q != '1)
                br_q <= br_q + 32'd1;
            if (flush_d && mp_q != '1)
                mp_q <= mp_q + 32'd1;
            if (fifo_drop && dr_q != '1)
                dr_q <= dr_q + 32'd1;
        end
    end

    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;
    assign stat_drops       = dr_q;
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized + directed bench for btb_update_ctrl with a queue-based reference model.
module tb_btb_update_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 0, ex_is_branch = 0, ex_pred_hit = 0, ex_actual_taken = 0, hold = 0;
    logic [31:0] ex_pc = 0, ex_pred_target = 0, ex_actual_target = 0;
    logic        flush, upd_en, upd_taken, fifo_full;
    logic [31:0] redirect_pc, upd_pc, upd_target;
`ifdef BTB_UPDATE_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts, stat_drops;
`endif

    always #5 clk = ~clk;

    btb_update_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_pred_hit      (ex_pred_hit),
        .ex_pred_target   (ex_pred_target),
        .ex_actual_taken  (ex_actual_taken),
        .ex_actual_target (ex_actual_target),
        .hold             (hold),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .upd_en           (upd_en),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .fifo_full        (fifo_full)
`ifdef BTB_UPDATE_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
        .stat_drops       (stat_drops)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } exp_upd_t;

    exp_upd_t    upd_q[$];
    logic [31:0] redir_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state: occupancy, pending flush, event totals
    int          m_cnt = 0;
    bit          m_flush = 0;
    int unsigned m_br = 0, m_mp = 0, m_dr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT presents an update or a flush, pop and compare
    initial begin
        exp_upd_t e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (rst_n && upd_en) begin
                if (upd_q.size() == 0) begin
                    chk("upd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = upd_q.pop_front();
                    chk("upd_pc", upd_pc, e.pc);
                    chk("upd_target", upd_target, e.target);
                    chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
                end
            end
            if (rst_n && flush) begin
                if (redir_q.size() == 0) begin
                    chk("flush_unexpected", 32'd1, 32'd0);
                end else begin
                    r = redir_q.pop_front();
                    chk("redirect_pc", redirect_pc, r);
                end
            end
        end
    end

    // One clock of stimulus; the model decides what the DUT owes and queues it
    task automatic step(input bit v, input bit br, input logic [31:0] pc, input bit hit,
                        input logic [31:0] ptgt, input bit tk, input logic [31:0] atgt,
                        input bit hd);
        bit res, mp, pop, enq;
        exp_upd_t e;
        @(posedge clk);
        #1;
        ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_pred_hit = hit;
        ex_pred_target = ptgt; ex_actual_taken = tk; ex_actual_target = atgt; hold = hd;

        res = v && br && !m_flush;
        mp  = (hit != tk) || (hit && tk && ptgt != atgt);
        pop = (m_cnt > 0) && !hd;
        enq = res && (tk || hit);
        if (res && mp)
            redir_q.push_back(tk ? atgt : pc + 32'd4);
        if (enq) begin
            if (m_cnt < DEPTH || pop) begin
                e.pc = pc; e.target = atgt; e.taken = tk;
                upd_q.push_back(e);
            end else begin
                m_dr++;
            end
        end

        @(negedge clk);
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("upd_en", {31'd0, upd_en}, {31'd0, pop});
        chk("fifo_full", {31'd0, fifo_full}, {31'd0, (m_cnt == DEPTH)});
        if (m_cnt == 0)
            chk("upd_pc_empty", upd_pc, 32'd0);

        if (res) m_br++;
        if (res && mp) m_mp++;
        if (enq && (m_cnt < DEPTH || pop)) m_cnt++;
        if (pop) m_cnt--;
        m_flush = res && mp;
    endtask

    task automatic idle(input int n, input bit hd);
        for (int i = 0; i < n; i++)
            step(0, 0, 32'd0, 0, 32'd0, 0, 32'd0, hd);
    endtask

    task automatic check_stats;
`ifdef BTB_UPDATE_STATS_EN
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mp);
        chk("stat_drops", stat_drops, m_dr);
`endif
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately
    task automatic do_reset;
        @(posedge clk);
        #2;
        ex_valid = 0; ex_is_branch = 0; hold = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_upd_en", {31'd0, upd_en}, 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        upd_q.delete();
        redir_q.delete();
        m_cnt = 0; m_flush = 0; m_br = 0; m_mp = 0; m_dr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_stats();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pcs [8];
        logic [31:0] tgts [4];
        do_reset();
        idle(2, 0);

        // Correct taken prediction: no flush, update next cycle
        step(1, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0);
        idle(2, 0);
        // BTB miss, taken
        step(1, 1, 32'h40, 0, 32'h0, 1, 32'h80, 0);
        idle(2, 0);
        // Target mispredict, followed by a wrong-path mispredicting branch
        step(1, 1, 32'h10, 1, 32'h300, 1, 32'h340, 0);
        step(1, 1, 32'h20, 0, 32'h0, 1, 32'h999, 0);
        idle(2, 0);
        // Fall-through wraps to zero
        step(1, 1, 32'hFFFF_FFFC, 1, 32'h1234, 0, 32'h1234, 0);
        idle(3, 0);

        // Five correct predictions under hold: fifth is dropped
        for (int i = 0; i < 5; i++)
            step(1, 1, 32'h1000 + 32'(i * 16), 1, 32'h2000 + 32'(i * 4), 1,
                 32'h2000 + 32'(i * 4), 1);
        idle(1, 1);
        check_stats();
        idle(6, 0);

        // Reset with three queued entries and a flush pending
        step(1, 1, 32'h500, 1, 32'h600, 1, 32'h600, 1);
        step(1, 1, 32'h504, 1, 32'h700, 1, 32'h700, 1);
        step(1, 1, 32'h508, 0, 32'h0, 1, 32'h800, 1);
        do_reset();
        idle(4, 0);

        // Randomized traffic over a small PC/target pool to exercise same-PC ordering
        for (int i = 0; i < 8; i++) pcs[i] = ($urandom() & 32'hFFFF_FFFC);
        pcs[7] = 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) tgts[i] = ($urandom() & 32'hFFFF_FFFC);
        for (int i = 0; i < 600; i++) begin
            bit hit, tk, hd;
            logic [31:0] pt, at;
            hit = $urandom_range(0, 1) == 1;
            tk  = $urandom_range(0, 1) == 1;
            pt  = tgts[$urandom_range(0, 3)];
            at  = ($urandom_range(0, 1) == 1) ? pt : tgts[$urandom_range(0, 3)];
            hd  = ($urandom_range(0, 9) < ((i / 100) % 2 == 1 ? 8 : 2));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 pcs[$urandom_range(0, 7)], hit, pt, tk, at, hd);
        end
        idle(DEPTH + 3, 0);
        check_stats();
        chk("upd_q_drained", 32'(upd_q.size()), 32'd0);
        chk("redir_q_drained", 32'(redir_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
